// File: rtl/regfile_pkg.sv
// Shared constants for the multi-ported register file.
// No logic; default sizing and the hardwired-zero register index.
// No flow control.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ADDR_W_DEF    = 5;
  localparam int unsigned NUM_RD_DEF    = 2;
  localparam int unsigned ZERO_REG_ADDR = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One register-file read port: zero check, write-first bypass, operand-ready flag.
// Fully combinational, 0 cycles from address/write inputs to data/ready.
// No backpressure; rd_ready only reports whether the operand is still pending.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              pend_bit,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ready
);

  logic rd_zero;
  logic hit0;
  logic hit1;

  assign rd_zero = (rd_addr == ADDR_W'(ZERO_REG_ADDR));
  assign hit0    = wr0_en && (wr0_addr == rd_addr);
  assign hit1    = wr1_en && (wr1_addr == rd_addr);

  // Select array data, overridden by same-cycle writes (wr1 last so it wins); bypass off during reset.
  always_comb begin
    rd_data  = arr_data;
    rd_ready = !pend_bit;
    if (rd_zero) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end else if (rst) begin
      if (hit0) begin
        rd_data = wr0_data;
      end
      if (hit1) begin
        rd_data  = wr1_data;
        rd_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with load-pending scoreboard (optional debug read: REGFILE_DEBUG_EN).
// Reads 0-cycle combinational with write-first bypass; writes and pending updates commit at the next clk edge.
// No backpressure; rd_ready flags operands whose producing load has not yet written back.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic [2**ADDR_W-1:0]     pend_vec
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0]        debug_addr,
  output logic [DATA_W-1:0]        debug_data
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              set_ok;

  assign wr0_ok   = wr0_en   && (wr0_addr  != ADDR_W'(ZERO_REG_ADDR));
  assign wr1_ok   = wr1_en   && (wr1_addr  != ADDR_W'(ZERO_REG_ADDR));
  assign set_ok   = pend_set && (pend_addr != ADDR_W'(ZERO_REG_ADDR));
  assign pend_vec = pend_q;

  // Commit writes; wr1 is applied after wr0 so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        mem[wr0_addr] <= wr0_data;
      end
      if (wr1_ok) begin
        mem[wr1_addr] <= wr1_data;
      end
    end
  end

  // Next pending vector: load writeback clears, a new load issue sets and takes priority.
  always_comb begin
    pend_nxt = pend_q;
    if (wr1_ok) begin
      pend_nxt[wr1_addr] = 1'b0;
    end
    if (set_ok) begin
      pend_nxt[pend_addr] = 1'b1;
    end
  end

  // Pending scoreboard register; reset drops all in-flight loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .rst      (rst),
      .rd_addr  (addr_k),
      .arr_data (mem[addr_k]),
      .pend_bit (pend_q[addr_k]),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_ready (rd_ready[k])
    );
  end

`ifdef REGFILE_DEBUG_EN
  // Raw array view for debug; never bypassed.
  assign debug_data = (debug_addr == ADDR_W'(ZERO_REG_ADDR)) ? '0 : mem[debug_addr];
`else
  // Debug read path not built in this configuration.
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios then randomized traffic vs an array model.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Ends with a one-line summary.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_ready;
  logic              wr0_en;
  logic [AW-1:0]     wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic              pend_set;
  logic [AW-1:0]     pend_addr;
  logic [DEPTH-1:0]  pend_vec;

  int tests_run;
  int tests_failed;

  // Reference model: architectural register contents and pending flags.
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [DEPTH-1:0] ref_pend;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .pend_vec  (pend_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    pend_set = 1'b0; pend_addr = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] port_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // Compare outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    logic          exp_r;
    #3;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      exp_d = ref_mem[a];
      exp_r = !ref_pend[a];
      if (a == 0) begin
        exp_d = '0;
        exp_r = 1'b1;
      end else if (rst) begin
        if (wr0_en && wr0_addr == a) exp_d = wr0_data;
        if (wr1_en && wr1_addr == a) begin
          exp_d = wr1_data;
          exp_r = 1'b1;
        end
      end
      chk($sformatf("rd_data%0d", k), 64'(port_data(k)), 64'(exp_d));
      if (rst) chk($sformatf("rd_ready%0d", k), 64'(rd_ready[k]), 64'(exp_r));
    end
    chk("pend_vec", 64'(pend_vec), 64'(ref_pend));
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_pend = '0;
    end else begin
      if (wr0_en && wr0_addr != 0) ref_mem[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) begin
        ref_mem[wr1_addr] = wr1_data;
        ref_pend[wr1_addr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) ref_pend[pend_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_pend = '0;

    // Reset state: r5 on both ports
    rst = 1'b1;
    set_rd(0, 5); set_rd(1, 5);
    #1;
    chk("rst_rd0", 64'(port_data(0)), 64'h0);
    chk("rst_rd1", 64'(port_data(1)), 64'h0);
    chk("rst_ready", 64'(rd_ready), 64'h3);
    chk("rst_pend", 64'(pend_vec), 64'h0);
    cycle();

    // Same-cycle bypass of wr0, then persistence
    wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'hDEADBEEF;
    set_rd(0, 3); set_rd(1, 3);
    #1;
    chk("byp_wr0", 64'(port_data(0)), 64'hDEADBEEF);
    cycle();
    idle();
    #1;
    chk("held_wr0", 64'(port_data(1)), 64'hDEADBEEF);
    cycle();

    // wr0 and wr1 collide on r7: wr1 wins
    wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'h22;
    set_rd(0, 7);
    #1;
    chk("coll_byp", 64'(port_data(0)), 64'h22);
    cycle();
    idle();
    #1;
    chk("coll_arr", 64'(port_data(0)), 64'h22);
    cycle();

    // Pending r9, cleared by load writeback with bypass
    pend_set = 1'b1; pend_addr = 9;
    cycle();
    idle();
    set_rd(0, 9);
    #1;
    chk("pend_notready", 64'(rd_ready[0]), 64'h0);
    cycle();
    wr1_en = 1'b1; wr1_addr = 9; wr1_data = 32'h55;
    #1;
    chk("wr1_ready", 64'(rd_ready[0]), 64'h1);
    chk("wr1_byp", 64'(port_data(0)), 64'h55);
    cycle();
    idle();
    #1;
    chk("pend9_clr", 64'(pend_vec[9]), 64'h0);
    cycle();

    // Set beats clear on r4; writes to r0 discarded
    pend_set = 1'b1; pend_addr = 4;
    wr1_en = 1'b1; wr1_addr = 4; wr1_data = 32'h1;
    cycle();
    idle();
    #1;
    chk("pend4_set", 64'(pend_vec[4]), 64'h1);
    wr0_en = 1'b1; wr0_addr = 0; wr0_data = 32'hFFFF;
    set_rd(0, 0);
    #1;
    chk("r0_byp", 64'(port_data(0)), 64'h0);
    cycle();
    idle();
    #1;
    chk("r0_arr", 64'(port_data(0)), 64'h0);
    chk("r0_ready", 64'(rd_ready[0]), 64'h1);
    cycle();

    // Mid-operation reset drops data and pending state
    pend_set = 1'b1; pend_addr = 12;
    wr0_en = 1'b1; wr0_addr = 12; wr0_data = 32'hAB;
    cycle();
    idle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    set_rd(0, 12);
    #1;
    chk("rst12_data", 64'(port_data(0)), 64'h0);
    chk("rst12_pend", 64'(pend_vec[12]), 64'h0);
    chk("rst12_ready", 64'(rd_ready[0]), 64'h1);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) != 0);
      wr0_en    = 1'($urandom_range(0, 1));
      wr0_addr  = rnd_addr();
      wr0_data  = $urandom;
      wr1_en    = 1'($urandom_range(0, 1));
      wr1_addr  = rnd_addr();
      wr1_data  = $urandom;
      pend_set  = 1'($urandom_range(0, 1));
      pend_addr = rnd_addr();
      for (int k = 0; k < NR; k++) set_rd(k, rnd_addr());
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
